// File: rtl/vin_pkg.sv
// Shared helpers for the DPI video input front-end: PPW legality,
// polarity normalisation and saturating counter increment.
package vin_pkg;

  localparam int IGN_W = 4;

  function automatic bit ppw_legal(input int ppw);
    return (ppw == 1) || (ppw == 2) || (ppw == 4);
  endfunction

  // Maps a raw pin level to "1 = asserted" for the given pin polarity.
  function automatic logic pol_norm(input logic raw, input bit active_high);
    return raw ^ ~active_high;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val == max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/vin_dpi_pack_shift.sv
// Pixel packer: gathers PPW stage-1 pixels into one word (first pixel in the
// MSBs) and flushes a zero-padded partial word when DE falls mid-group.
module vin_pack_shift
  import vin_pkg::*;
#(
  parameter int PIX_W = 24,
  parameter int PPW   = 2
) (
  input  logic                 pclk,
  input  logic                 rst_out,
  input  logic                 en,
  input  logic                 de,
  input  logic                 de_rise,
  input  logic                 de_fall,
  input  logic [PIX_W-1:0]     pix,
  output logic                 strobe,
  output logic                 partial,
  output logic [PIX_W*PPW-1:0] word,
  output logic                 flush_partial
);

  localparam int K_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam logic [K_W-1:0] LAST = K_W'(PPW - 1);

  logic [K_W-1:0]       k_q, k_d, slot;
  logic [PIX_W*PPW-1:0] acc_q, acc_d, word_q, word_d;
  logic                 strobe_q, strobe_d, partial_q, partial_d;

  always_comb begin
    slot          = de_rise ? '0 : k_q;
    k_d           = k_q;
    acc_d         = acc_q;
    word_d        = word_q;
    strobe_d      = 1'b0;
    partial_d     = 1'b0;
    flush_partial = 1'b0;
    if (de) begin
      // Starting a group clears the accumulator so a later flush pads with zeros.
      if (slot == '0) acc_d = '0;
      acc_d[(PPW-1-int'(slot))*PIX_W +: PIX_W] = pix;
      if (slot == LAST) begin
        strobe_d = en;
        word_d   = acc_d;
        k_d      = '0;
      end else begin
        k_d = slot + K_W'(1);
      end
    end else if (de_fall && (k_q != '0)) begin
      flush_partial = 1'b1;
      strobe_d      = en;
      partial_d     = en;
      word_d        = acc_q;
      k_d           = '0;
    end
  end

  always_ff @(posedge pclk or posedge rst_out) begin
    if (rst_out) begin
      k_q       <= '0;
      acc_q     <= '0;
      word_q    <= '0;
      strobe_q  <= 1'b0;
      partial_q <= 1'b0;
    end else begin
      k_q       <= k_d;
      acc_q     <= acc_d;
      word_q    <= word_d;
      strobe_q  <= strobe_d;
      partial_q <= partial_d;
    end
  end

  assign strobe  = strobe_q;
  assign partial = partial_q;
  assign word    = word_q;

endmodule

// File: rtl/vin_dpi_pack.sv
// DPI video input front-end: registers and normalises the pins, packs pixels,
// suppresses the first frames after reset and measures active timing.
module vin_dpi_pack
  import vin_pkg::*;
#(
  parameter int PIX_W         = 24,
  parameter int PPW           = 2,
  parameter int IGNORE_FRAMES = 3,
  parameter bit HSYNC_POL     = 1'b1,
  parameter bit VSYNC_POL     = 1'b1,
  parameter bit DE_POL        = 1'b1,
  parameter int CNT_W         = 12
) (
  input  logic                 pclk,
  input  logic                 rst_out,
  input  logic                 dpi_vsync,
  input  logic                 dpi_hsync,
  input  logic                 dpi_de,
  input  logic [PIX_W-1:0]     dpi_pixel,
  output logic                 v_vsync,
  output logic                 v_hsync,
  output logic                 v_de,
  output logic                 v_strobe,
  output logic [PIX_W*PPW-1:0] v_pixel,
  output logic                 v_partial,
  output logic                 frame_start,
  output logic [CNT_W-1:0]     h_active,
  output logic [CNT_W-1:0]     v_active,
  output logic                 timing_valid,
  output logic                 line_err
);

  if (!ppw_legal(PPW)) begin : g_bad_ppw
    $error("vin_dpi_pack: PPW must be 1, 2 or 4");
  end

  logic             s1_vs_q, s1_vs_d, s1_hs_q, s1_hs_d, s1_de_q, s1_de_d;
  logic [PIX_W-1:0] s1_pix_q, s1_pix_d;
  logic             vs_prev_q, vs_prev_d, de_prev_q, de_prev_d;
  logic             v_vsync_q, v_vsync_d, v_hsync_q, v_hsync_d, v_de_q, v_de_d;
  logic             frame_start_q, frame_start_d;
  logic [IGN_W-1:0] ign_q, ign_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, first_h_q, first_h_d;
  logic [CNT_W-1:0] frame_h_q, frame_h_d, h_active_q, h_active_d, v_active_q, v_active_d;
  logic             tv_q, tv_d, line_err_q, line_err_d;
  logic             de_rise, de_fall, vs_rise, ignoring, flush_partial, err_new;
  logic [CNT_W-1:0] h_new, v_new;

  vin_pack_shift #(.PIX_W(PIX_W), .PPW(PPW)) u_pack (
    .pclk          (pclk),
    .rst_out       (rst_out),
    .en            (~ignoring),
    .de            (s1_de_q),
    .de_rise       (de_rise),
    .de_fall       (de_fall),
    .pix           (s1_pix_q),
    .strobe        (v_strobe),
    .partial       (v_partial),
    .word          (v_pixel),
    .flush_partial (flush_partial)
  );

  always_comb begin
    s1_vs_d  = pol_norm(dpi_vsync, VSYNC_POL);
    s1_hs_d  = pol_norm(dpi_hsync, HSYNC_POL);
    s1_de_d  = pol_norm(dpi_de, DE_POL);
    s1_pix_d = dpi_pixel;
    vs_prev_d = s1_vs_q;
    de_prev_d = s1_de_q;

    de_rise  = s1_de_q & ~de_prev_q;
    de_fall  = ~s1_de_q & de_prev_q;
    vs_rise  = s1_vs_q & ~vs_prev_q;
    ignoring = (ign_q != '0);

    v_vsync_d     = s1_vs_q & ~ignoring;
    v_hsync_d     = s1_hs_q & ~ignoring;
    v_de_d        = s1_de_q & ~ignoring;
    frame_start_d = vs_rise & ~ignoring;
    ign_d         = (vs_rise && ignoring) ? ign_q - IGN_W'(1) : ign_q;

    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    first_h_d  = first_h_q;
    frame_h_d  = frame_h_q;
    v_active_d = v_active_q;
    tv_d       = tv_q;
    h_new      = h_active_q;
    v_new      = v_cnt_q;
    err_new    = line_err_q | flush_partial;

    if (s1_de_q) begin
      h_cnt_d = CNT_W'(sat_inc(32'(h_cnt_q), CNT_W));
    end else if (de_fall) begin
      h_cnt_d = '0;
      h_new   = h_cnt_q;
      v_new   = CNT_W'(sat_inc(32'(v_cnt_q), CNT_W));
      // The first line of a frame sets the reference width for the rest.
      if (v_cnt_q == '0) first_h_d = h_cnt_q;
      else if (h_cnt_q != first_h_q) err_new = 1'b1;
    end
    h_active_d = h_new;
    v_cnt_d    = v_new;
    line_err_d = err_new;

    // A line ending on the same cycle as vsync still belongs to the closing frame.
    if (vs_rise) begin
      v_active_d = v_new;
      v_cnt_d    = '0;
      tv_d       = (h_new == frame_h_q) && (v_new == v_active_q) && (v_new != '0) && !err_new;
      frame_h_d  = h_new;
      line_err_d = 1'b0;
    end
  end

  always_ff @(posedge pclk or posedge rst_out) begin
    if (rst_out) begin
      s1_vs_q       <= 1'b0;
      s1_hs_q       <= 1'b0;
      s1_de_q       <= 1'b0;
      s1_pix_q      <= '0;
      vs_prev_q     <= 1'b0;
      de_prev_q     <= 1'b0;
      v_vsync_q     <= 1'b0;
      v_hsync_q     <= 1'b0;
      v_de_q        <= 1'b0;
      frame_start_q <= 1'b0;
      ign_q         <= IGN_W'(IGNORE_FRAMES);
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      first_h_q     <= '0;
      frame_h_q     <= '0;
      h_active_q    <= '0;
      v_active_q    <= '0;
      tv_q          <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      s1_vs_q       <= s1_vs_d;
      s1_hs_q       <= s1_hs_d;
      s1_de_q       <= s1_de_d;
      s1_pix_q      <= s1_pix_d;
      vs_prev_q     <= vs_prev_d;
      de_prev_q     <= de_prev_d;
      v_vsync_q     <= v_vsync_d;
      v_hsync_q     <= v_hsync_d;
      v_de_q        <= v_de_d;
      frame_start_q <= frame_start_d;
      ign_q         <= ign_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      first_h_q     <= first_h_d;
      frame_h_q     <= frame_h_d;
      h_active_q    <= h_active_d;
      v_active_q    <= v_active_d;
      tv_q          <= tv_d;
      line_err_q    <= line_err_d;
    end
  end

  assign v_vsync      = v_vsync_q;
  assign v_hsync      = v_hsync_q;
  assign v_de         = v_de_q;
  assign frame_start  = frame_start_q;
  assign h_active     = h_active_q;
  assign v_active     = v_active_q;
  assign timing_valid = tv_q;
  assign line_err     = line_err_q;

endmodule

// File: tb/tb_vin_dpi_pack.sv
// Directed bench for vin_dpi_pack: four instances (PPW=2, PPW=4, ignoring,
// inverted DE/HSYNC) share one stimulus stream and are checked against constants.
module tb_vin_dpi_pack;

  logic        pclk = 1'b0;
  logic        rst_out = 1'b1;
  logic        dpi_vsync = 1'b0, dpi_hsync = 1'b0, dpi_de = 1'b0;
  logic [23:0] dpi_pixel = '0;
  logic        dpi_de_n, dpi_hsync_n;

  assign dpi_de_n    = ~dpi_de;
  assign dpi_hsync_n = ~dpi_hsync;

  always #5 pclk = ~pclk;

  logic        a_vs, a_hs, a_de, a_st, a_part, a_fs, a_tv, a_err;
  logic [47:0] a_pix;
  logic [11:0] a_hact, a_vact;
  logic        b_vs, b_hs, b_de, b_st, b_part, b_fs, b_tv, b_err;
  logic [95:0] b_pix;
  logic [11:0] b_hact, b_vact;
  logic        c_vs, c_hs, c_de, c_st, c_part, c_fs, c_tv, c_err;
  logic [47:0] c_pix;
  logic [11:0] c_hact, c_vact;
  logic        d_vs, d_hs, d_de, d_st, d_part, d_fs, d_tv, d_err;
  logic [47:0] d_pix;
  logic [11:0] d_hact, d_vact;

  vin_dpi_pack #(.PPW(2), .IGNORE_FRAMES(0)) u_a (
    .pclk(pclk), .rst_out(rst_out), .dpi_vsync(dpi_vsync), .dpi_hsync(dpi_hsync),
    .dpi_de(dpi_de), .dpi_pixel(dpi_pixel), .v_vsync(a_vs), .v_hsync(a_hs), .v_de(a_de),
    .v_strobe(a_st), .v_pixel(a_pix), .v_partial(a_part), .frame_start(a_fs),
    .h_active(a_hact), .v_active(a_vact), .timing_valid(a_tv), .line_err(a_err));

  vin_dpi_pack #(.PPW(4), .IGNORE_FRAMES(0)) u_b (
    .pclk(pclk), .rst_out(rst_out), .dpi_vsync(dpi_vsync), .dpi_hsync(dpi_hsync),
    .dpi_de(dpi_de), .dpi_pixel(dpi_pixel), .v_vsync(b_vs), .v_hsync(b_hs), .v_de(b_de),
    .v_strobe(b_st), .v_pixel(b_pix), .v_partial(b_part), .frame_start(b_fs),
    .h_active(b_hact), .v_active(b_vact), .timing_valid(b_tv), .line_err(b_err));

  vin_dpi_pack #(.PPW(2), .IGNORE_FRAMES(3)) u_c (
    .pclk(pclk), .rst_out(rst_out), .dpi_vsync(dpi_vsync), .dpi_hsync(dpi_hsync),
    .dpi_de(dpi_de), .dpi_pixel(dpi_pixel), .v_vsync(c_vs), .v_hsync(c_hs), .v_de(c_de),
    .v_strobe(c_st), .v_pixel(c_pix), .v_partial(c_part), .frame_start(c_fs),
    .h_active(c_hact), .v_active(c_vact), .timing_valid(c_tv), .line_err(c_err));

  vin_dpi_pack #(.PPW(2), .IGNORE_FRAMES(0), .DE_POL(1'b0), .HSYNC_POL(1'b0)) u_d (
    .pclk(pclk), .rst_out(rst_out), .dpi_vsync(dpi_vsync), .dpi_hsync(dpi_hsync_n),
    .dpi_de(dpi_de_n), .dpi_pixel(dpi_pixel), .v_vsync(d_vs), .v_hsync(d_hs), .v_de(d_de),
    .v_strobe(d_st), .v_pixel(d_pix), .v_partial(d_part), .frame_start(d_fs),
    .h_active(d_hact), .v_active(d_vact), .timing_valid(d_tv), .line_err(d_err));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int line_start_cyc = 0;

  // Monitor state: event counters and captured output words, sampled on the falling edge.
  int a_de_cnt = 0, a_hs_cnt = 0, a_fs_cnt = 0, a_vde_cyc = 0;
  bit a_vde_seen = 1'b0;
  int c_de_cnt = 0, c_st_cnt = 0, c_fs_cnt = 0;
  int d_de_cnt = 0, d_hs_cnt = 0;
  logic [47:0] qa_word[$];
  logic        qa_part[$];
  int          qa_dec[$];
  logic [95:0] qb_word[$];
  logic        qb_part[$];
  logic [47:0] qd_word[$];

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin
    if (a_de) a_de_cnt <= a_de_cnt + 1;
    if (a_hs) a_hs_cnt <= a_hs_cnt + 1;
    if (a_fs) a_fs_cnt <= a_fs_cnt + 1;
    if (a_de && !a_vde_seen) begin
      a_vde_seen <= 1'b1;
      a_vde_cyc  <= cyc;
    end
    if (a_st) begin
      qa_word.push_back(a_pix);
      qa_part.push_back(a_part);
      qa_dec.push_back(a_de_cnt + (a_de ? 1 : 0));
    end
    if (b_st) begin
      qb_word.push_back(b_pix);
      qb_part.push_back(b_part);
    end
    if (c_de) c_de_cnt <= c_de_cnt + 1;
    if (c_st) c_st_cnt <= c_st_cnt + 1;
    if (c_fs) c_fs_cnt <= c_fs_cnt + 1;
    if (d_de) d_de_cnt <= d_de_cnt + 1;
    if (d_hs) d_hs_cnt <= d_hs_cnt + 1;
    if (d_st) qd_word.push_back(d_pix);
  end

  task automatic checkOutput(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic vs, input logic hs, input logic de, input logic [23:0] pix);
    @(negedge pclk);
    dpi_vsync = vs;
    dpi_hsync = hs;
    dpi_de    = de;
    dpi_pixel = pix;
  endtask

  task automatic sendLine(input int n, input logic [23:0] base);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, base + 24'(i));
      if (i == 0) line_start_cyc = cyc;
    end
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
    repeat (2) applyStimulus(1'b0, 1'b1, 1'b0, 24'h0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic sendVsync();
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 24'h0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic settle();
    @(posedge pclk);
    #2;
  endtask

  task automatic doReset();
    @(negedge pclk);
    rst_out = 1'b1;
    dpi_vsync = 1'b0; dpi_hsync = 1'b0; dpi_de = 1'b0; dpi_pixel = '0;
    repeat (3) @(negedge pclk);
    rst_out = 1'b0;
  endtask

  int qa_base, qb_base, qd_base, de_base, hs_base, dhs_base, dde_base;
  int cde_base, cst_base, cfs_base, afs_base;
  int rows;

  initial begin
    // Reset state
    repeat (3) @(negedge pclk);
    checkOutput("rst_v_de", 96'(a_de), 96'(0));
    checkOutput("rst_v_strobe", 96'(a_st), 96'(0));
    checkOutput("rst_v_pixel", 96'(a_pix), 96'(0));
    checkOutput("rst_h_active", 96'(a_hact), 96'(0));
    checkOutput("rst_v_active", 96'(a_vact), 96'(0));
    checkOutput("rst_timing_valid", 96'(a_tv), 96'(0));
    checkOutput("rst_line_err", 96'(a_err), 96'(0));
    checkOutput("rst_frame_start", 96'(a_fs), 96'(0));
    rst_out = 1'b0;

    // 4-pixel line, PPW=2: two full words, latency 2 cycles from the pin
    qa_base = qa_word.size(); qd_base = qd_word.size(); de_base = a_de_cnt;
    sendLine(4, 24'h111100);
    settle();
    checkOutput("latency_v_de", 96'(a_vde_cyc - line_start_cyc), 96'(2));
    checkOutput("ppw2_nstrobe", 96'(qa_word.size() - qa_base), 96'(2));
    if (qa_word.size() >= qa_base + 2) begin
      checkOutput("ppw2_word0", 96'(qa_word[qa_base]), 96'(48'h111100_111101));
      checkOutput("ppw2_word1", 96'(qa_word[qa_base+1]), 96'(48'h111102_111103));
      checkOutput("ppw2_part0", 96'(qa_part[qa_base]), 96'(0));
      checkOutput("ppw2_part1", 96'(qa_part[qa_base+1]), 96'(0));
      checkOutput("ppw2_strobe0_align", 96'(qa_dec[qa_base] - de_base), 96'(2));
      checkOutput("ppw2_strobe1_align", 96'(qa_dec[qa_base+1] - de_base), 96'(4));
    end
    checkOutput("ppw2_h_active", 96'(a_hact), 96'(4));
    checkOutput("ppw2_line_err", 96'(a_err), 96'(0));
    checkOutput("invpol_nstrobe", 96'(qd_word.size() - qd_base), 96'(2));
    if (qd_word.size() >= qd_base + 2) begin
      checkOutput("invpol_word0", 96'(qd_word[qd_base]), 96'(48'h111100_111101));
      checkOutput("invpol_word1", 96'(qd_word[qd_base+1]), 96'(48'h111102_111103));
    end

    // 6-pixel line, PPW=4: one full word then a zero-padded partial word
    qb_base = qb_word.size();
    sendLine(6, 24'h222200);
    settle();
    checkOutput("ppw4_nstrobe", 96'(qb_word.size() - qb_base), 96'(2));
    if (qb_word.size() >= qb_base + 2) begin
      checkOutput("ppw4_word0", qb_word[qb_base], 96'h222200_222201_222202_222203);
      checkOutput("ppw4_word1", qb_word[qb_base+1], 96'h222204_222205_000000_000000);
      checkOutput("ppw4_part0", 96'(qb_part[qb_base]), 96'(0));
      checkOutput("ppw4_part1", 96'(qb_part[qb_base+1]), 96'(1));
    end
    checkOutput("ppw4_line_err_set", 96'(b_err), 96'(1));
    checkOutput("ppw2_h_active_6", 96'(a_hact), 96'(6));
    sendVsync();
    settle();
    checkOutput("ppw4_line_err_clr", 96'(b_err), 96'(0));
    checkOutput("ppw2_v_active_2", 96'(a_vact), 96'(2));
    checkOutput("ppw2_tv_first", 96'(a_tv), 96'(0));

    // Timing and ignore: frames 8x4, 8x4, 8x5, 8x5, 8x5 from a fresh reset
    doReset();
    hs_base = a_hs_cnt; dhs_base = d_hs_cnt; dde_base = d_de_cnt; afs_base = a_fs_cnt;
    cde_base = c_de_cnt; cst_base = c_st_cnt; cfs_base = c_fs_cnt;
    for (int f = 1; f <= 5; f++) begin
      rows = (f <= 2) ? 4 : 5;
      for (int r = 0; r < rows; r++) sendLine(8, 24'h300000 + 24'(r * 16));
      settle();
      if (f == 4) begin
        checkOutput("ign_f4_de", 96'(c_de_cnt - cde_base), 96'(40));
        checkOutput("ign_f4_strobe", 96'(c_st_cnt - cst_base), 96'(20));
        checkOutput("ign_f4_fs_before", 96'(c_fs_cnt - cfs_base), 96'(0));
      end
      sendVsync();
      settle();
      case (f)
        1: checkOutput("tv_f1", 96'(a_tv), 96'(0));
        2: begin
          checkOutput("tv_f2", 96'(a_tv), 96'(1));
          checkOutput("tv_f2_v_active", 96'(a_vact), 96'(4));
          checkOutput("tv_f2_h_active", 96'(a_hact), 96'(8));
          checkOutput("invpol_tv_f2", 96'(d_tv), 96'(1));
          checkOutput("ign_tv_f2", 96'(c_tv), 96'(1));
        end
        3: begin
          checkOutput("tv_f3", 96'(a_tv), 96'(0));
          checkOutput("tv_f3_v_active", 96'(a_vact), 96'(5));
          checkOutput("ign_f3_de", 96'(c_de_cnt - cde_base), 96'(0));
          checkOutput("ign_f3_strobe", 96'(c_st_cnt - cst_base), 96'(0));
          checkOutput("ign_f3_fs", 96'(c_fs_cnt - cfs_base), 96'(0));
        end
        4: begin
          checkOutput("tv_f4", 96'(a_tv), 96'(1));
          checkOutput("ign_f4_fs_after", 96'(c_fs_cnt - cfs_base), 96'(1));
          checkOutput("noign_fs_count", 96'(a_fs_cnt - afs_base), 96'(4));
        end
        default: checkOutput("ign_f5_de", 96'(c_de_cnt - cde_base), 96'(80));
      endcase
    end
    checkOutput("hsync_count", 96'(a_hs_cnt - hs_base), 96'(46));
    checkOutput("invpol_hsync_count", 96'(d_hs_cnt - dhs_base), 96'(46));
    checkOutput("invpol_de_count", 96'(d_de_cnt - dde_base), 96'(184));

    // Reset after the first pixel of a pair: nothing emitted, next line packs from slot 0
    doReset();
    qa_base = qa_word.size();
    applyStimulus(1'b0, 1'b0, 1'b1, 24'h4444AA);
    @(negedge pclk);
    rst_out = 1'b1;
    dpi_de  = 1'b0;
    repeat (2) @(negedge pclk);
    rst_out = 1'b0;
    sendLine(2, 24'h555500);
    settle();
    checkOutput("rstmid_nstrobe", 96'(qa_word.size() - qa_base), 96'(1));
    if (qa_word.size() >= qa_base + 1) begin
      checkOutput("rstmid_word", 96'(qa_word[qa_base]), 96'(48'h555500_555501));
      checkOutput("rstmid_part", 96'(qa_part[qa_base]), 96'(0));
    end
    checkOutput("rstmid_h_active", 96'(a_hact), 96'(2));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
